// File: rtl/ras_ctrl.sv
// Return-address-stack controller: two cached top entries in flops,
// circular pointer with overwrite-oldest, refill/restore via dual-port BRAM.
module ras_ctrl #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 36,
  localparam int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             pop,
  input  logic             restore_valid,
  input  logic [ADDR-1:0]  restore_tos,
  input  logic [ADDR:0]    restore_count,
  output logic             ready,
  output logic             top_valid,
  output logic [WIDTH-1:0] top_addr,
  output logic [ADDR-1:0]  tos,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic             mem_rea,
  output logic             mem_reb,
  output logic             mem_wea,
  output logic             mem_web,
  output logic [ADDR-1:0]  mem_raddra,
  output logic [ADDR-1:0]  mem_raddrb,
  output logic [ADDR-1:0]  mem_waddra,
  output logic [ADDR-1:0]  mem_waddrb,
  output logic [WIDTH-1:0] mem_wia,
  output logic [WIDTH-1:0] mem_wib,
  input  logic [WIDTH-1:0] mem_doa,
  input  logic [WIDTH-1:0] mem_dob
);

  typedef enum logic [1:0] {
    S_READY,
    S_REFILL,
    S_RESTORE
  } state_e;

  localparam logic [ADDR:0] FULL = (ADDR+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic [ADDR-1:0]  tos_q, tos_d;
  logic [ADDR:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic empty;
  logic do_push;
  logic do_repl;
  logic do_pop;
  logic do_unf;

  assign empty   = (count_q == '0);
  assign do_push = push && (!pop || empty);
  assign do_repl = push && pop && !empty;
  assign do_pop  = !push && pop && !empty;
  assign do_unf  = !push && pop && empty;

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    next_d     = next_q;
    tos_d      = tos_q;
    count_d    = count_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    mem_rea    = 1'b0;
    mem_reb    = 1'b0;
    mem_wea    = 1'b0;
    mem_raddra = '0;
    mem_raddrb = '0;
    mem_waddra = '0;
    mem_wia    = '0;
    if (!rst) begin
      if (restore_valid) begin
        tos_d      = restore_tos;
        count_d    = (restore_count > FULL) ? FULL : restore_count;
        mem_rea    = 1'b1;
        mem_raddra = restore_tos;
        mem_reb    = 1'b1;
        mem_raddrb = restore_tos - ADDR'(1);
        state_d    = S_RESTORE;
      end else begin
        unique case (state_q)
          S_READY: begin
            unique case (1'b1)
              do_push: begin
                mem_wea    = 1'b1;
                mem_waddra = tos_q + ADDR'(1);
                mem_wia    = push_addr;
                tos_d      = tos_q + ADDR'(1);
                next_d     = top_q;
                top_d      = push_addr;
                if (count_q == FULL) ovf_d = 1'b1;
                else count_d = count_q + 1'b1;
              end
              do_repl: begin
                mem_wea    = 1'b1;
                mem_waddra = tos_q;
                mem_wia    = push_addr;
                top_d      = push_addr;
              end
              do_pop: begin
                top_d      = next_q;
                tos_d      = tos_q - ADDR'(1);
                count_d    = count_q - 1'b1;
                mem_reb    = 1'b1;
                mem_raddrb = tos_q - ADDR'(2);
                state_d    = S_REFILL;
              end
              do_unf: unf_d = 1'b1;
              default: ;
            endcase
          end
          S_REFILL: begin
            next_d  = mem_dob;
            state_d = S_READY;
          end
          S_RESTORE: begin
            top_d   = mem_doa;
            next_d  = mem_dob;
            state_d = S_READY;
          end
          default: state_d = S_READY;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_READY;
      top_q   <= '0;
      next_q  <= '0;
      tos_q   <= ADDR'(DEPTH - 1);
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      next_q  <= next_d;
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ready      = (state_q == S_READY);
  assign top_valid  = ready && !empty;
  assign top_addr   = empty ? '0 : top_q;
  assign tos        = tos_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign mem_web    = 1'b0;
  assign mem_waddrb = '0;
  assign mem_wib    = '0;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl (DEPTH=4) with a behavioural dual-port BRAM.
module tb_ras_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 36;
  localparam int ADDR  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic [WIDTH-1:0] push_addr;
  logic             pop;
  logic             restore_valid;
  logic [ADDR-1:0]  restore_tos;
  logic [ADDR:0]    restore_count;
  logic             ready, top_valid;
  logic [WIDTH-1:0] top_addr;
  logic [ADDR-1:0]  tos;
  logic [ADDR:0]    count;
  logic             overflow, underflow;
  logic             mem_rea, mem_reb, mem_wea, mem_web;
  logic [ADDR-1:0]  mem_raddra, mem_raddrb, mem_waddra, mem_waddrb;
  logic [WIDTH-1:0] mem_wia, mem_wib, mem_doa, mem_dob;

  logic [WIDTH-1:0] ram [DEPTH];

  int passed = 0;
  int total  = 0;

  ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_addr(push_addr), .pop(pop),
    .restore_valid(restore_valid), .restore_tos(restore_tos),
    .restore_count(restore_count),
    .ready(ready), .top_valid(top_valid), .top_addr(top_addr),
    .tos(tos), .count(count),
    .overflow(overflow), .underflow(underflow),
    .mem_rea(mem_rea), .mem_reb(mem_reb),
    .mem_wea(mem_wea), .mem_web(mem_web),
    .mem_raddra(mem_raddra), .mem_raddrb(mem_raddrb),
    .mem_waddra(mem_waddra), .mem_waddrb(mem_waddrb),
    .mem_wia(mem_wia), .mem_wib(mem_wib),
    .mem_doa(mem_doa), .mem_dob(mem_dob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wea) ram[mem_waddra] <= mem_wia;
    if (mem_web) ram[mem_waddrb] <= mem_wib;
    if (mem_rea) mem_doa <= ram[mem_raddra];
    if (mem_reb) mem_dob <= ram[mem_raddrb];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] a);
    push = 1'b1;
    push_addr = a;
    step();
    push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    push = 0; pop = 0; push_addr = '0;
    restore_valid = 0; restore_tos = '0; restore_count = '0;
    mem_doa = '0; mem_dob = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    do_reset();

    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_top_valid", 64'(top_valid), 64'd0);
    chk("rst_top_addr", 64'(top_addr), 64'd0);
    chk("rst_tos", 64'(tos), 64'd3);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_flags", 64'({overflow, underflow}), 64'd0);
    chk("rst_mem_en", 64'({mem_rea, mem_reb, mem_wea, mem_web}), 64'd0);

    // push three, then pop
    do_push(36'h100);
    do_push(36'h200);
    do_push(36'h300);
    chk("p3_count", 64'(count), 64'd3);
    chk("p3_tos", 64'(tos), 64'd2);
    chk("p3_top", 64'(top_addr), 64'h300);
    chk("p3_valid", 64'(top_valid), 64'd1);
    pop = 1'b1;
    #1;
    chk("pop_reb", 64'({mem_reb, mem_raddrb}), 64'({1'b1, 2'd0}));
    step();
    pop = 1'b0;
    chk("pop_top", 64'(top_addr), 64'h200);
    chk("pop_ready_lo", 64'(ready), 64'd0);
    chk("pop_count", 64'(count), 64'd2);
    step();
    chk("pop_ready_hi", 64'(ready), 64'd1);
    do_pop();
    chk("pop2_top", 64'(top_addr), 64'h100);
    step();

    // overflow with DEPTH=4
    do_reset();
    for (int i = 1; i <= 4; i++) do_push(36'(i));
    chk("full_count", 64'(count), 64'd4);
    chk("full_no_ovf", 64'(overflow), 64'd0);
    do_push(36'h5);
    chk("ovf_pulse", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_tos", 64'(tos), 64'd0);
    chk("ovf_top", 64'(top_addr), 64'h5);
    step();
    chk("ovf_cleared", 64'(overflow), 64'd0);
    for (int v = 5; v >= 2; v--) begin
      chk("ovf_pop_val", 64'(top_addr), 64'(v));
      do_pop();
      step();
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(top_valid), 64'd0);
    chk("drain_top", 64'(top_addr), 64'd0);

    // underflow
    pop = 1'b1;
    #1;
    chk("unf_mem_en", 64'({mem_rea, mem_reb, mem_wea, mem_web}), 64'd0);
    step();
    pop = 1'b0;
    chk("unf_pulse", 64'(underflow), 64'd1);
    chk("unf_count", 64'(count), 64'd0);
    chk("unf_valid", 64'(top_valid), 64'd0);
    chk("unf_ready", 64'(ready), 64'd1);
    step();
    chk("unf_cleared", 64'(underflow), 64'd0);

    // push+pop replaces top
    do_reset();
    do_push(36'hA);
    do_push(36'hB);
    push = 1'b1; pop = 1'b1; push_addr = 36'hC;
    #1;
    chk("repl_wr", 64'({mem_wea, mem_waddra}), 64'({1'b1, 2'd1}));
    step();
    push = 1'b0; pop = 1'b0;
    chk("repl_top", 64'(top_addr), 64'hC);
    chk("repl_count", 64'(count), 64'd2);
    chk("repl_ready", 64'(ready), 64'd1);
    chk("repl_tos", 64'(tos), 64'd1);
    do_pop();
    chk("repl_pop", 64'(top_addr), 64'hA);
    step();

    // checkpoint and restore
    do_reset();
    do_push(36'h10);
    do_push(36'h20);
    chk("cp_tos", 64'(tos), 64'd1);
    chk("cp_count", 64'(count), 64'd2);
    do_push(36'h30);
    do_pop();
    step();
    do_pop();
    step();
    restore_valid = 1'b1; restore_tos = 2'd1; restore_count = 3'd2;
    #1;
    chk("rs_rd", 64'({mem_rea, mem_raddra, mem_reb, mem_raddrb}),
        64'({1'b1, 2'd1, 1'b1, 2'd0}));
    step();
    restore_valid = 1'b0;
    chk("rs_ready_lo", 64'(ready), 64'd0);
    step();
    chk("rs_ready_hi", 64'(ready), 64'd1);
    chk("rs_top", 64'(top_addr), 64'h20);
    chk("rs_count", 64'(count), 64'd2);
    chk("rs_tos", 64'(tos), 64'd1);
    do_pop();
    chk("rs_pop", 64'(top_addr), 64'h10);
    step();

    // restore during REFILL, count clamp
    do_push(36'h40);
    do_push(36'h50);
    do_pop();
    chk("rf_state", 64'(ready), 64'd0);
    restore_valid = 1'b1; restore_tos = 2'd0; restore_count = 3'd7;
    step();
    restore_valid = 1'b0;
    chk("rf_rs_ready_lo", 64'(ready), 64'd0);
    chk("rf_rs_count", 64'(count), 64'd4);
    chk("rf_rs_tos", 64'(tos), 64'd0);
    step();
    chk("rf_rs_ready_hi", 64'(ready), 64'd1);
    chk("rf_rs_top", 64'(top_addr), 64'h10);

    // reset during REFILL
    do_pop();
    chk("rr_refill", 64'(ready), 64'd0);
    do_reset();
    chk("rr_ready", 64'(ready), 64'd1);
    chk("rr_count", 64'(count), 64'd0);
    chk("rr_tos", 64'(tos), 64'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Controller for the dual-port return-address-stack BRAM. It turns branch-predictor push/pop requests and misprediction restores into BRAM port operations. It keeps the top two stack entries in registers, so the current top is readable with zero latency. It manages a circular top-of-stack pointer with overwrite-oldest overflow. It sits between the predictor front-end and the `ras_bram` instance and owns all of that RAM's ports.

## Interface
Parameters:
- DEPTH, 1024, stack entries; must match the BRAM's DEPTH; power of two.
- WIDTH, 36, return-address width; must match the BRAM's WIDTH.
- ADDR, localparam $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- push  in  1  call: push push_addr; honoured only when ready.
- push_addr  in  WIDTH  return address to push.
- pop  in  1  return: pop top; honoured only when ready.
- restore_valid  in  1  misprediction restore; accepted in any state, highest priority.
- restore_tos  in  ADDR  checkpointed pointer.
- restore_count  in  ADDR+1  checkpointed occupancy; values above DEPTH clamp to DEPTH.
- ready  out  1  controller accepts push/pop this cycle.
- top_valid  out  1  ready && count!=0.
- top_addr  out  WIDTH  current top entry; 0 when the stack is empty.
- tos  out  ADDR  current pointer, used for checkpointing.
- count  out  ADDR+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a push overwrote the oldest entry.
- underflow  out  1  one-cycle pulse: pop while empty.
- mem_rea, mem_reb, mem_wea, mem_web  out  1  BRAM enables; mem_web is tied 0.
- mem_raddra, mem_raddrb, mem_waddra, mem_waddrb  out  ADDR  BRAM addresses.
- mem_wia, mem_wib  out  WIDTH  BRAM write data; mem_wib is tied 0.
- mem_doa, mem_dob  in  WIDTH  BRAM read data, valid one cycle after the read enable.

## Operation
- State: top_q, next_q (entry at tos-1), tos, count, and FSM {READY, REFILL, RESTORE}. ready = (state==READY).
- All pointer arithmetic is modulo DEPTH (ADDR bits, natural wrap).
- Push only (READY):
  - Port A writes push_addr to tos+1.
  - tos <= tos+1; next_q <= top_q; top_q <= push_addr.
  - If count==DEPTH, count stays DEPTH and overflow pulses; the oldest entry is silently overwritten. Otherwise count+1.
  - State stays READY.
- Pop only (READY, count>0):
  - top_q <= next_q; tos <= tos-1; count-1.
  - Port B reads tos-2 to refill next_q. State goes to REFILL.
- Pop only (READY, count==0): no state change, no BRAM access, underflow pulses.
- Push and pop together (READY): replace top.
  - Port A writes push_addr to tos; top_q <= push_addr.
  - tos, count and next_q are unchanged. No refill is needed.
  - If count==0, the pair behaves as a plain push and underflow does not pulse.
- REFILL: next_q <= mem_dob; state goes to READY. push and pop are ignored here (ready=0).
- Restore (any state):
  - tos <= restore_tos; count <= min(restore_count, DEPTH).
  - Port A reads restore_tos; port B reads restore_tos-1. State goes to RESTORE.
  - A restore aborts a pending REFILL and overrides any push/pop in the same cycle.
- RESTORE: top_q <= mem_doa; next_q <= mem_dob; state goes to READY. A new restore_valid in this cycle restarts RESTORE with the new values.
- Entries overwritten after a checkpoint are not recovered; this imprecision is accepted RAS behaviour.
- Contents of next_q and of refill reads are don't-care when count<2.
- Port A and port B never address the same location in the same cycle, so BRAM collision handling is not required.

## Timing
- Reset values:
  - state=READY, tos=DEPTH-1, count=0, top_q=next_q=0.
  - ready=1, top_valid=0, top_addr=0, overflow=underflow=0.
  - All mem_* enables 0, addresses 0, data 0.
- top_addr/top_valid are registered and reflect all accepted operations on the next cycle.
- Push: zero-bubble; back-to-back pushes are allowed every cycle.
- Pop: 2 cycles per pop (one REFILL bubble). The new top is visible the cycle after the pop.
- Restore: ready drops for exactly 1 cycle; top_addr is valid 2 cycles after restore_valid.
- mem_* outputs are combinational from state and inputs in the issuing cycle. Read data is sampled exactly one cycle later.
- rst mid-REFILL or mid-RESTORE returns all state to reset values. BRAM contents are not cleared.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles.
  - Required: count=3, tos=2, top_addr=0x300.
  - Then pop: top_addr=0x200 next cycle, ready=0 for 1 cycle, count=2.
- DEPTH=4: push 0x1..0x5.
  - Required: overflow pulses on the fifth push, count=4, tos=0.
  - Then pop four times: returns 0x5, 0x4, 0x3, 0x2; then empty.
- Empty stack, pop.
  - Required: underflow pulses 1 cycle, count=0, top_valid=0, no BRAM enable asserted.
- Stack {0xA, 0xB}, push 0xC and pop in the same cycle.
  - Required: top_addr=0xC, count=2, no REFILL.
  - A subsequent pop yields 0xA.
- Push 0x10, 0x20 and checkpoint (tos=1, count=2). Then push 0x30 and pop twice. Then restore.
  - Required: after 2 cycles, top_addr=0x20, count=2; the next pop yields 0x10.
- Restore in the same cycle as a pop-induced REFILL.
  - Required: the REFILL is discarded, the restore values win, and ready returns 1 cycle later.
